// File: rtl/jtdsp16_sio_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtdsp16_sio_rx_if
//  Purpose  : Bundles the DSP16 serial-output pins and the receiver's
//             decoded word/sample outputs into one interface.
//  Ports    : (interface signals)
//             ock, sio_do, sadd, old         serial link from the DSP16
//             word[15:0], addr[7:0], word_stb last complete word + strobe
//             left[15:0], right[15:0]        demultiplexed samples
//             l_stb, r_stb                   sample update strobes
//             frame_err                      aborted-word strobe
//  Modports : master - drives the serial link (DSP16 side / testbench)
//             slave  - receives the link (jtdsp16_sio_rx)
//  Revision : 1.0 - initial release
// ============================================================================
interface jtdsp16_sio_rx_if;
  logic        ock;
  logic        sio_do;
  logic        sadd;
  logic        old;
  logic [15:0] word;
  logic [7:0]  addr;
  logic        word_stb;
  logic [15:0] left;
  logic [15:0] right;
  logic        l_stb;
  logic        r_stb;
  logic        frame_err;

  modport master (
    output ock, sio_do, sadd, old,
    input  word, addr, word_stb, left, right, l_stb, r_stb, frame_err
  );

  modport slave (
    input  ock, sio_do, sadd, old,
    output word, addr, word_stb, left, right, l_stb, r_stb, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/jtdsp16_sio_rx.sv
`default_nettype none
// ============================================================================
//  Module   : jtdsp16_sio_rx
//  Purpose  : Far end of the DSP16 serial-output link (Q-Sound DAC side).
//             Deserialises 16-bit MSB-first words together with the 8-bit
//             sadd address stream and routes each word to a left or right
//             sample register according to its address.
//  Ports    : clk        system clock
//             rst        synchronous reset, active-high
//             cen        clock enable qualifying every state update
//             sio        jtdsp16_sio_rx_if.slave (serial link + outputs)
//  Params   : ADDR_L     sadd address of the left channel
//             ADDR_R     sadd address of the right channel
//  Options  : JTDSP16_SIO_RX_SYNC_EN - when defined, ock/sio_do/sadd/old pass
//             a 2-stage cen-qualified synchroniser (adds 2 cen cycles of
//             latency, alignment between the four pins is preserved).
//  Revision : 1.0 - initial release
// ============================================================================
module jtdsp16_sio_rx #(
  parameter logic [7:0] ADDR_L = 8'h00,
  parameter logic [7:0] ADDR_R = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  jtdsp16_sio_rx_if.slave    sio
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // waiting for the first data edge of a word
    SHIFT = 2'd1,   // bits 14..0 arriving
    DONE  = 2'd2    // all 16 bits held in sr, publish this cycle
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic ock_s, do_s, sadd_s, old_s;

`ifdef JTDSP16_SIO_RX_SYNC_EN
  logic [1:0] ock_q, do_q, sadd_q, old_q;

  // All four pins share identical stages so relative timing is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ock_q  <= 2'b00;
      do_q   <= 2'b00;
      sadd_q <= 2'b00;
      old_q  <= 2'b00;
    end else if (cen) begin
      ock_q  <= {ock_q[0],  sio.ock};
      do_q   <= {do_q[0],   sio.sio_do};
      sadd_q <= {sadd_q[0], sio.sadd};
      old_q  <= {old_q[0],  sio.old};
    end
  end

  assign ock_s  = ock_q[1];
  assign do_s   = do_q[1];
  assign sadd_s = sadd_q[1];
  assign old_s  = old_q[1];
`else
  assign ock_s  = sio.ock;
  assign do_s   = sio.sio_do;
  assign sadd_s = sio.sadd;
  assign old_s  = sio.old;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t      state, state_nx;
  logic        last_ock;
  logic [15:0] sr;
  logic [7:0]  asr;
  logic [4:0]  cnt;

  logic [15:0] word_q, left_q, right_q;
  logic [7:0]  addr_q;
  logic        word_stb_q, l_stb_q, r_stb_q, frame_err_q;

  logic        rise;
  logic        start_word;   // capture bit 15, cnt <= 1
  logic        shift_bit;    // capture bits 14..0
  logic        finish_word;  // publish sr/asr
  logic        abort_word;   // old rose before bit 0

  assign rise = ock_s & ~last_ock;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (cen) begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    start_word  = 1'b0;
    shift_bit   = 1'b0;
    finish_word = 1'b0;
    abort_word  = 1'b0;
    case (state)
      IDLE: begin
        // A rise with old high is the DSP's load edge and is ignored.
        if (rise && !old_s) begin
          start_word = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (old_s) begin
          abort_word = 1'b1;
          state_nx   = IDLE;
        end else if (rise) begin
          shift_bit = 1'b1;
          if (cnt == 5'd15) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        finish_word = 1'b1;
        // Back-to-back words: a data edge in the publish cycle already
        // carries bit 15 of the next word.
        if (rise && !old_s) begin
          start_word = 1'b1;
          state_nx   = SHIFT;
        end else begin
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ock    <= 1'b0;
      sr          <= 16'd0;
      asr         <= 8'd0;
      cnt         <= 5'd0;
      word_q      <= 16'd0;
      addr_q      <= 8'd0;
      left_q      <= 16'd0;
      right_q     <= 16'd0;
      word_stb_q  <= 1'b0;
      l_stb_q     <= 1'b0;
      r_stb_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (cen) begin
      last_ock    <= ock_s;
      word_stb_q  <= 1'b0;
      l_stb_q     <= 1'b0;
      r_stb_q     <= 1'b0;
      frame_err_q <= 1'b0;

      if (finish_word) begin
        word_q     <= sr;
        addr_q     <= asr;
        word_stb_q <= 1'b1;
        // Left is checked first so it wins when ADDR_L == ADDR_R.
        if (asr == ADDR_L) begin
          left_q  <= sr;
          l_stb_q <= 1'b1;
        end else if (asr == ADDR_R) begin
          right_q <= sr;
          r_stb_q <= 1'b1;
        end
      end

      if (start_word) begin
        // Stale low bits are shifted out before the word completes.
        sr  <= {sr[14:0], do_s};
        asr <= {asr[6:0], sadd_s};
        cnt <= 5'd1;
      end else if (shift_bit) begin
        sr  <= {sr[14:0], do_s};
        cnt <= cnt + 5'd1;
        // sadd only carries address bits alongside data bits 15..8.
        if (cnt < 5'd8) begin
          asr <= {asr[6:0], sadd_s};
        end
      end else if (abort_word) begin
        sr          <= 16'd0;
        cnt         <= 5'd0;
        frame_err_q <= 1'b1;
      end else if (finish_word) begin
        cnt <= 5'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sio.word      = word_q;
  assign sio.addr      = addr_q;
  assign sio.word_stb  = word_stb_q;
  assign sio.left      = left_q;
  assign sio.right     = right_q;
  assign sio.l_stb     = l_stb_q;
  assign sio.r_stb     = r_stb_q;
  assign sio.frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_sio_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtdsp16_sio_rx
//  Purpose  : Directed self-checking bench for jtdsp16_sio_rx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtdsp16_sio_rx;

`ifdef JTDSP16_SIO_RX_SYNC_EN
  localparam int LAT = 4;   // cen cycles from bit-0 rise edge to strobe seen
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cen;
  int   cen_mode;   // 0: always on, 1: one cycle in three
  int   cen_phase;

  int checks = 0;
  int errors = 0;

  jtdsp16_sio_rx_if bus();

  jtdsp16_sio_rx #(.ADDR_L(8'h00), .ADDR_R(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .sio (bus)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters and pulse width (in clk cycles) of word_stb.
  int   w_cnt = 0, l_cnt = 0, r_cnt = 0, fe_cnt = 0;
  int   w_cur = 0, w_last = 0;
  logic pw = 1'b0, pl = 1'b0, pr = 1'b0, pf = 1'b0;

  always @(negedge clk) begin
    if (bus.word_stb && !pw) w_cnt++;
    if (bus.l_stb && !pl) l_cnt++;
    if (bus.r_stb && !pr) r_cnt++;
    if (bus.frame_err && !pf) fe_cnt++;
    if (bus.word_stb) w_cur++;
    else if (w_cur > 0) begin
      w_last = w_cur;
      w_cur  = 0;
    end
    pw = bus.word_stb;
    pl = bus.l_stb;
    pr = bus.r_stb;
    pf = bus.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (cen_mode == 0) cen = 1'b1;
    else begin
      cen_phase = (cen_phase + 1) % 3;
      cen = (cen_phase == 0);
    end
  endtask

  // Advance until an edge with cen high has happened.
  task automatic cen_step();
    logic had;
    do begin
      had = cen;
      step();
    end while (!had);
  endtask

  task automatic half(input int n);
    for (int k = 0; k < n; k++) cen_step();
  endtask

  // Sends the first nbits of d (MSB first) with address a; ock period 12 cen.
  task automatic send_bits(input logic [15:0] d, input logic [7:0] a, input int nbits,
                           input bit load_edge, output int lat);
    lat = -1;
    if (load_edge) begin
      bus.old = 1'b1;
      bus.ock = 1'b0;
      half(6);
      bus.ock = 1'b1;
      half(6);
    end
    for (int i = 15; i > 15 - nbits; i--) begin
      bus.ock    = 1'b0;
      bus.old    = 1'b0;
      bus.sio_do = d[i];
      bus.sadd   = (i >= 8) ? a[i-8] : 1'b1;
      half(6);
      bus.ock = 1'b1;
      if (i == 0) begin
        for (int k = 1; k <= 6; k++) begin
          cen_step();
          if (bus.word_stb && lat < 0) lat = k;
        end
      end else begin
        half(6);
      end
    end
    bus.ock = 1'b0;
  endtask

  int lat;
  int w0, l0, r0, f0;

  initial begin
    rst = 1'b1; cen = 1'b1; cen_mode = 0; cen_phase = 0;
    bus.ock = 1'b0; bus.sio_do = 1'b0; bus.sadd = 1'b0; bus.old = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_word",  {16'd0, bus.word}, 32'h0);
    check("rst_addr",  {24'd0, bus.addr}, 32'h0);
    check("rst_left",  {16'd0, bus.left}, 32'h0);
    check("rst_right", {16'd0, bus.right}, 32'h0);
    check("rst_stbs",  {28'd0, bus.word_stb, bus.l_stb, bus.r_stb, bus.frame_err}, 32'h0);

    // 1: left channel
    send_bits(16'h1234, 8'h00, 16, 1'b1, lat);
    half(3);
    check("t1_left",  {16'd0, bus.left}, 32'h1234);
    check("t1_word",  {16'd0, bus.word}, 32'h1234);
    check("t1_addr",  {24'd0, bus.addr}, 32'h00);
    check("t1_right", {16'd0, bus.right}, 32'h0);
    check("t1_lat",   lat, LAT);
    check("t1_cnts",  {w_cnt[7:0], l_cnt[7:0], r_cnt[7:0], fe_cnt[7:0]}, 32'h01010000);
    check("t1_width", w_last, 1);

    // 2: right channel
    send_bits(16'h8001, 8'h01, 16, 1'b1, lat);
    half(3);
    check("t2_right", {16'd0, bus.right}, 32'h8001);
    check("t2_left",  {16'd0, bus.left}, 32'h1234);
    check("t2_cnts",  {w_cnt[7:0], l_cnt[7:0], r_cnt[7:0], fe_cnt[7:0]}, 32'h02010100);

    // 3: unmatched address
    send_bits(16'hBEEF, 8'h5A, 16, 1'b1, lat);
    half(3);
    check("t3_word",  {16'd0, bus.word}, 32'hBEEF);
    check("t3_addr",  {24'd0, bus.addr}, 32'h5A);
    check("t3_cnts",  {w_cnt[7:0], l_cnt[7:0], r_cnt[7:0], fe_cnt[7:0]}, 32'h03010100);
    check("t3_lr",    {bus.left, bus.right}, 32'h12348001);

    // 4: abort after 7 bits, then a good word
    send_bits(16'hA5A5, 8'h00, 7, 1'b1, lat);
    bus.old = 1'b1;
    half(6);
    check("t4_fe",    fe_cnt, 1);
    check("t4_word",  {16'd0, bus.word}, 32'hBEEF);
    check("t4_left",  {16'd0, bus.left}, 32'h1234);
    check("t4_wcnt",  w_cnt, 3);
    send_bits(16'h0042, 8'h00, 16, 1'b1, lat);
    half(3);
    check("t4_next",  {16'd0, bus.left}, 32'h0042);

    // 5: two words back to back, old kept low between them
    w0 = w_cnt; l0 = l_cnt; r0 = r_cnt;
    send_bits(16'h0F0F, 8'h00, 16, 1'b1, lat);
    send_bits(16'hF0F0, 8'h01, 16, 1'b0, lat);
    half(3);
    check("t5_left",  {16'd0, bus.left}, 32'h0F0F);
    check("t5_right", {16'd0, bus.right}, 32'hF0F0);
    check("t5_wcnt",  w_cnt - w0, 2);
    check("t5_lr",    {l_cnt[15:0] - l0[15:0], r_cnt[15:0] - r0[15:0]}, 32'h00010001);

    // 6: reset mid-word after 9 bits
    w0 = w_cnt; f0 = fe_cnt;
    send_bits(16'hFFFF, 8'h01, 9, 1'b1, lat);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_outs",  {bus.left | bus.right, bus.word}, 32'h0);
    check("t6_addr",  {24'd0, bus.addr}, 32'h0);
    half(6);
    check("t6_nostb", {w_cnt - w0, fe_cnt - f0}, 64'h0);
    send_bits(16'hABCD, 8'h00, 16, 1'b1, lat);
    half(3);
    check("t6_next",  {16'd0, bus.left}, 32'hABCD);

    // 7: test 1 repeated with cen active one clk in three
    rst = 1'b1;
    step();
    rst = 1'b0;
    cen_mode = 1;
    l0 = l_cnt; w0 = w_cnt;
    send_bits(16'h1234, 8'h00, 16, 1'b1, lat);
    half(3);
    check("t7_left",  {16'd0, bus.left}, 32'h1234);
    check("t7_right", {16'd0, bus.right}, 32'h0);
    check("t7_lat",   lat, LAT);
    check("t7_cnts",  {l_cnt[15:0] - l0[15:0], w_cnt[15:0] - w0[15:0]}, 32'h00010001);
    check("t7_width", w_last, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the design never lets the sequence progress.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
